// File: rtl/hd_dma_pkg.sv
// Shared definitions for the HD <-> main memory word copy engine.
package hd_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LER,
    ESPERA,
    ESCREVER,
    FIM
  } estado_t;

  localparam logic DIR_HD_MEM = 1'b0;
  localparam logic DIR_MEM_HD = 1'b1;

endpackage

// File: rtl/hd_dma_contador.sv
// Word index, read-latency wait counter and HD/memory address generation
// for the copy engine.
module hd_dma_contador #(
  parameter int MEM_AW   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              limpar,
  input  logic              avancar,
  input  logic              espera_limpar,
  input  logic              espera_avancar,
  input  logic [31:0]       base_hd,
  input  logic [MEM_AW-1:0] base_mem,
  input  logic [31:0]       tamanho,
  output logic [31:0]       addr_hd,
  output logic [MEM_AW-1:0] addr_mem,
  output logic              ultima,
  output logic              espera_fim
);

  localparam int WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  logic [31:0]       idx;
  logic [WAIT_W-1:0] espera;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      espera <= '0;
    end else begin
      if (limpar)
        idx <= '0;
      else if (avancar)
        idx <= idx + 32'd1;
      if (espera_limpar)
        espera <= '0;
      else if (espera_avancar)
        espera <= espera + WAIT_W'(1);
    end
  end

  // Memory side wraps naturally at 2^MEM_AW.
  assign addr_hd    = base_hd + idx;
  assign addr_mem   = base_mem + MEM_AW'(idx);
  assign ultima     = (({1'b0, idx} + 33'd1) == {1'b0, tamanho});
  assign espera_fim = (espera == WAIT_W'(READ_LAT - 1));

endmodule

// File: rtl/hd_dma_carregador.sv
// Copy engine that loads (HD->MEM) or saves (MEM->HD) a process image word by word.
// All outputs are registered; the FSM owns every output register.
module hd_dma_carregador
  import hd_dma_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int HD_WORDS = 51,
  parameter int CTX_W    = 32,
  parameter int MEM_AW   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iniciar,
  input  logic              direcao,
  input  logic [CTX_W-1:0]  contexto,
  input  logic [31:0]       end_hd,
  input  logic [MEM_AW-1:0] end_mem,
  input  logic [31:0]       tamanho,
  output logic              ocupado,
  output logic              concluido,
  output logic              erro,
  output logic [31:0]       hd_endereco,
  output logic [CTX_W-1:0]  hd_contexto,
  output logic [DATA_W-1:0] hd_dado_escrita,
  output logic              hd_escrita,
  input  logic [DATA_W-1:0] hd_dado_saida,
  output logic [MEM_AW-1:0] mem_endereco,
  output logic [DATA_W-1:0] mem_dado_escrita,
  output logic              mem_escrita,
  input  logic [DATA_W-1:0] mem_dado_leitura
);

  estado_t           estado;
  logic              dir_r;
  logic [31:0]       base_hd;
  logic [MEM_AW-1:0] base_mem;
  logic [31:0]       tam_r;
  logic [31:0]       addr_hd;
  logic [MEM_AW-1:0] addr_mem;
  logic              ultima;
  logic              espera_fim;
  logic              fora_limite;

  // 33-bit sum so a huge end_hd cannot wrap back into range.
  assign fora_limite = ({1'b0, end_hd} + {1'b0, tamanho}) > 33'(HD_WORDS);

  hd_dma_contador #(
    .MEM_AW  (MEM_AW),
    .READ_LAT(READ_LAT)
  ) u_contador (
    .clk           (clk),
    .rst_n         (rst_n),
    .limpar        (estado == IDLE),
    .avancar       (estado == ESCREVER),
    .espera_limpar (estado == LER),
    .espera_avancar(estado == ESPERA),
    .base_hd       (base_hd),
    .base_mem      (base_mem),
    .tamanho       (tam_r),
    .addr_hd       (addr_hd),
    .addr_mem      (addr_mem),
    .ultima        (ultima),
    .espera_fim    (espera_fim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado           <= IDLE;
      dir_r            <= DIR_HD_MEM;
      base_hd          <= '0;
      base_mem         <= '0;
      tam_r            <= '0;
      ocupado          <= 1'b0;
      concluido        <= 1'b0;
      erro             <= 1'b0;
      hd_endereco      <= '0;
      hd_contexto      <= '0;
      hd_dado_escrita  <= '0;
      hd_escrita       <= 1'b0;
      mem_endereco     <= '0;
      mem_dado_escrita <= '0;
      mem_escrita      <= 1'b0;
    end else begin
      concluido        <= 1'b0;
      erro             <= 1'b0;
      hd_escrita       <= 1'b0;
      mem_escrita      <= 1'b0;
      hd_dado_escrita  <= '0;
      mem_dado_escrita <= '0;
      case (estado)
        IDLE: begin
          if (iniciar) begin
            dir_r       <= direcao;
            base_hd     <= end_hd;
            base_mem    <= end_mem;
            tam_r       <= tamanho;
            hd_contexto <= contexto;
            if (tamanho == 32'd0) begin
              ocupado <= 1'b1;
              estado  <= FIM;
            end else if (fora_limite) begin
              erro <= 1'b1;
            end else begin
              ocupado <= 1'b1;
              estado  <= LER;
            end
          end
        end
        LER: begin
          if (dir_r == DIR_HD_MEM)
            hd_endereco <= addr_hd;
          else
            mem_endereco <= addr_mem;
          estado <= ESPERA;
        end
        ESPERA: begin
          if (espera_fim)
            estado <= ESCREVER;
        end
        ESCREVER: begin
          if (dir_r == DIR_HD_MEM) begin
            mem_endereco     <= addr_mem;
            mem_dado_escrita <= hd_dado_saida;
            mem_escrita      <= 1'b1;
          end else begin
            hd_endereco     <= addr_hd;
            hd_dado_escrita <= mem_dado_leitura;
            hd_escrita      <= 1'b1;
          end
          estado <= ultima ? FIM : LER;
        end
        FIM: begin
          concluido <= 1'b1;
          ocupado   <= 1'b0;
          estado    <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_dma_carregador.sv
// Directed bench for hd_dma_carregador: one instance with READ_LAT=1 (_a) and one with READ_LAT=3 (_b).
module tb_hd_dma_carregador;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        iniciar_a = 1'b0;
  logic        iniciar_b = 1'b0;
  logic        direcao = 1'b0;
  logic [31:0] contexto = '0;
  logic [31:0] end_hd = '0;
  logic [31:0] end_mem = '0;
  logic [31:0] tamanho = '0;

  logic        ocupado_a, concluido_a, erro_a, hd_escrita_a, mem_escrita_a;
  logic [31:0] hd_endereco_a, hd_contexto_a, hd_dado_escrita_a, mem_endereco_a, mem_dado_escrita_a;
  logic [31:0] hd_rd_a, mem_rd_a;
  logic        ocupado_b, concluido_b, erro_b, hd_escrita_b, mem_escrita_b;
  logic [31:0] hd_endereco_b, hd_contexto_b, hd_dado_escrita_b, mem_endereco_b, mem_dado_escrita_b;
  logic [31:0] hd_rd_b [0:2];
  logic [31:0] mem_rd_b [0:2];

  logic [31:0] mem_w_a [0:255];
  logic [31:0] hd_w_a [0:3][0:63];
  logic [31:0] mem_w_b [0:255];
  int          mem_cnt_a, hd_cnt_a, mem_cnt_b, both_cnt;

  int   checks = 0;
  int   failures = 0;
  int   done_cyc, err_cyc;
  logic ocup1, aborted;
  logic [7:0] ab_snap;
  int   mb, hb;

  always #5 clk = ~clk;

  hd_dma_carregador #(.READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar_a), .direcao(direcao), .contexto(contexto),
    .end_hd(end_hd), .end_mem(end_mem), .tamanho(tamanho),
    .ocupado(ocupado_a), .concluido(concluido_a), .erro(erro_a),
    .hd_endereco(hd_endereco_a), .hd_contexto(hd_contexto_a), .hd_dado_escrita(hd_dado_escrita_a),
    .hd_escrita(hd_escrita_a), .hd_dado_saida(hd_rd_a),
    .mem_endereco(mem_endereco_a), .mem_dado_escrita(mem_dado_escrita_a),
    .mem_escrita(mem_escrita_a), .mem_dado_leitura(mem_rd_a)
  );

  hd_dma_carregador #(.READ_LAT(3)) dut_lat3 (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar_b), .direcao(direcao), .contexto(contexto),
    .end_hd(end_hd), .end_mem(end_mem), .tamanho(tamanho),
    .ocupado(ocupado_b), .concluido(concluido_b), .erro(erro_b),
    .hd_endereco(hd_endereco_b), .hd_contexto(hd_contexto_b), .hd_dado_escrita(hd_dado_escrita_b),
    .hd_escrita(hd_escrita_b), .hd_dado_saida(hd_rd_b[2]),
    .mem_endereco(mem_endereco_b), .mem_dado_escrita(mem_dado_escrita_b),
    .mem_escrita(mem_escrita_b), .mem_dado_leitura(mem_rd_b[2])
  );

  // Source contents are fixed patterns so expected words can be written down by hand.
  function automatic logic [31:0] hd_pat(input logic [31:0] c, input logic [31:0] a);
    return 32'hC000_0000 | {14'd0, c[1:0], 16'd0} | {26'd0, a[5:0]};
  endfunction

  function automatic logic [31:0] mem_pat(input logic [31:0] a);
    return 32'hD000_0000 | {16'd0, a[15:0]};
  endfunction

  // Storage models: registered reads with the instance's latency, writes on strobe.
  always @(posedge clk) begin
    hd_rd_a     <= hd_pat(hd_contexto_a, hd_endereco_a);
    mem_rd_a    <= mem_pat(mem_endereco_a);
    hd_rd_b[0]  <= hd_pat(hd_contexto_b, hd_endereco_b);
    hd_rd_b[1]  <= hd_rd_b[0];
    hd_rd_b[2]  <= hd_rd_b[1];
    mem_rd_b[0] <= mem_pat(mem_endereco_b);
    mem_rd_b[1] <= mem_rd_b[0];
    mem_rd_b[2] <= mem_rd_b[1];
    if (mem_escrita_a) begin
      mem_w_a[mem_endereco_a[7:0]] <= mem_dado_escrita_a;
      mem_cnt_a <= mem_cnt_a + 1;
    end
    if (hd_escrita_a) begin
      hd_w_a[hd_contexto_a[1:0]][hd_endereco_a[5:0]] <= hd_dado_escrita_a;
      hd_cnt_a <= hd_cnt_a + 1;
    end
    if (mem_escrita_b) begin
      mem_w_b[mem_endereco_b[7:0]] <= mem_dado_escrita_b;
      mem_cnt_b <= mem_cnt_b + 1;
    end
    if ((hd_escrita_a && mem_escrita_a) || (hd_escrita_b && mem_escrita_b))
      both_cnt <= both_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Pulses iniciar so that it is sampled at edge 0, then counts cycles until concluido/erro.
  task automatic applyStimulus(input logic sel, input logic d, input logic [31:0] ctx,
                               input logic [31:0] ehd, input logic [31:0] emem,
                               input logic [31:0] tam, input int reissue_at, input int abort_at);
    int cyc;
    @(negedge clk);
    direcao = d; contexto = ctx; end_hd = ehd; end_mem = emem; tamanho = tam;
    if (sel) iniciar_b = 1'b1; else iniciar_a = 1'b1;
    done_cyc = -1; err_cyc = -1; ocup1 = 1'b0; aborted = 1'b0; ab_snap = 8'hFF;
    @(posedge clk); #1;
    cyc = 0;
    while (cyc < 200 && done_cyc < 0 && err_cyc < 0 && !aborted) begin
      iniciar_a = 1'b0; iniciar_b = 1'b0;
      if (cyc == reissue_at) begin
        if (sel) iniciar_b = 1'b1; else iniciar_a = 1'b1;
        direcao = ~d; end_mem = emem + 32'd5; tamanho = 32'd1; end_hd = 32'd2;
      end
      if (cyc == 1) ocup1 = sel ? ocupado_b : ocupado_a;
      if (sel ? concluido_b : concluido_a) done_cyc = cyc;
      else if (sel ? erro_b : erro_a) err_cyc = cyc;
      else if (cyc == abort_at) begin
        rst_n = 1'b0; #1;
        ab_snap = {ocupado_a, concluido_a, erro_a, hd_escrita_a, mem_escrita_a,
                   |mem_endereco_a, |hd_endereco_a, |hd_contexto_a};
        aborted = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    iniciar_a = 1'b0; iniciar_b = 1'b0;
    if (cyc >= 200) checkOutput("timeout", 32'd1, 32'd0);
    if (aborted) begin
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
    end
    repeat (4) @(posedge clk); #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #3;
    checkOutput("rst_ocupado", {31'd0, ocupado_a}, 32'd0);
    checkOutput("rst_concluido", {31'd0, concluido_a}, 32'd0);
    checkOutput("rst_strobes", {30'd0, hd_escrita_a, mem_escrita_a}, 32'd0);
    checkOutput("rst_mem_endereco", mem_endereco_a, 32'd0);
    checkOutput("rst_hd_contexto", hd_contexto_a, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Load ctx 1, HD[0..3] -> MEM[100..103]
    mb = mem_cnt_a; hb = hd_cnt_a;
    applyStimulus(1'b0, 1'b0, 32'd1, 32'd0, 32'd100, 32'd4, -1, -1);
    checkOutput("load_done_cycle", done_cyc, 32'd13);
    checkOutput("load_ocupado_c1", {31'd0, ocup1}, 32'd1);
    checkOutput("load_mem100", mem_w_a[100], 32'hC001_0000);
    checkOutput("load_mem101", mem_w_a[101], 32'hC001_0001);
    checkOutput("load_mem102", mem_w_a[102], 32'hC001_0002);
    checkOutput("load_mem103", mem_w_a[103], 32'hC001_0003);
    checkOutput("load_mem_pulses", mem_cnt_a - mb, 32'd4);
    checkOutput("load_hd_pulses", hd_cnt_a - hb, 32'd0);
    checkOutput("load_contexto", hd_contexto_a, 32'd1);
    checkOutput("load_ocupado_end", {31'd0, ocupado_a}, 32'd0);

    // Save ctx 2, MEM[0..2] -> HD[2][10..12]
    mb = mem_cnt_a; hb = hd_cnt_a;
    applyStimulus(1'b0, 1'b1, 32'd2, 32'd10, 32'd0, 32'd3, -1, -1);
    checkOutput("save_done_cycle", done_cyc, 32'd10);
    checkOutput("save_hd10", hd_w_a[2][10], 32'hD000_0000);
    checkOutput("save_hd11", hd_w_a[2][11], 32'hD000_0001);
    checkOutput("save_hd12", hd_w_a[2][12], 32'hD000_0002);
    checkOutput("save_hd_pulses", hd_cnt_a - hb, 32'd3);
    checkOutput("save_mem_pulses", mem_cnt_a - mb, 32'd0);

    // Zero-length transfer
    mb = mem_cnt_a; hb = hd_cnt_a;
    applyStimulus(1'b0, 1'b0, 32'd1, 32'd0, 32'd60, 32'd0, -1, -1);
    checkOutput("n0_done_cycle", done_cyc, 32'd1);
    checkOutput("n0_pulses", (mem_cnt_a - mb) + (hd_cnt_a - hb), 32'd0);

    // Out of range: 48 + 4 > 51
    mb = mem_cnt_a; hb = hd_cnt_a;
    applyStimulus(1'b0, 1'b0, 32'd1, 32'd48, 32'd70, 32'd4, -1, -1);
    checkOutput("range_err_cycle", err_cyc, 32'd0);
    checkOutput("range_no_done", done_cyc, 32'hFFFF_FFFF);
    checkOutput("range_pulses", (mem_cnt_a - mb) + (hd_cnt_a - hb), 32'd0);
    checkOutput("range_ocupado", {31'd0, ocupado_a}, 32'd0);

    // Exactly at the limit: 47 + 4 == 51
    mb = mem_cnt_a;
    applyStimulus(1'b0, 1'b0, 32'd1, 32'd47, 32'd200, 32'd4, -1, -1);
    checkOutput("limit_done_cycle", done_cyc, 32'd13);
    checkOutput("limit_mem200", mem_w_a[200], 32'hC001_002F);
    checkOutput("limit_mem203", mem_w_a[203], 32'hC001_0032);
    checkOutput("limit_mem_pulses", mem_cnt_a - mb, 32'd4);

    // Start request and input changes while busy are ignored
    mb = mem_cnt_a; hb = hd_cnt_a;
    applyStimulus(1'b0, 1'b0, 32'd1, 32'd0, 32'd120, 32'd2, 3, -1);
    checkOutput("busy_done_cycle", done_cyc, 32'd7);
    checkOutput("busy_mem120", mem_w_a[120], 32'hC001_0000);
    checkOutput("busy_mem121", mem_w_a[121], 32'hC001_0001);
    checkOutput("busy_mem_pulses", mem_cnt_a - mb, 32'd2);
    checkOutput("busy_hd_pulses", hd_cnt_a - hb, 32'd0);

    // Reset during word 2 of 4
    mb = mem_cnt_a;
    applyStimulus(1'b0, 1'b0, 32'd1, 32'd0, 32'd140, 32'd4, -1, 8);
    checkOutput("abort_taken", {31'd0, aborted}, 32'd1);
    checkOutput("abort_outputs", {24'd0, ab_snap}, 32'd0);
    checkOutput("abort_mem140", mem_w_a[140], 32'hC001_0000);
    checkOutput("abort_mem141", mem_w_a[141], 32'hC001_0001);
    checkOutput("abort_mem_pulses", mem_cnt_a - mb, 32'd2);

    mb = mem_cnt_a;
    applyStimulus(1'b0, 1'b0, 32'd3, 32'd7, 32'd150, 32'd1, -1, -1);
    checkOutput("restart_done_cycle", done_cyc, 32'd4);
    checkOutput("restart_mem150", mem_w_a[150], 32'hC003_0007);
    checkOutput("restart_mem_pulses", mem_cnt_a - mb, 32'd1);

    // READ_LAT = 3 instance
    mb = mem_cnt_b;
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd5, 32'd30, 32'd2, -1, -1);
    checkOutput("lat3_done_cycle", done_cyc, 32'd11);
    checkOutput("lat3_mem30", mem_w_b[30], 32'hC000_0005);
    checkOutput("lat3_mem31", mem_w_b[31], 32'hC000_0006);
    checkOutput("lat3_mem_pulses", mem_cnt_b - mb, 32'd2);

    checkOutput("never_both_strobes", both_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
